// File: rtl/prg_uploader_if.sv
// Upload-channel bundle: HPS ioctl upload request/response plus the shared-RAM read port.
// The slave side is the uploader; the master side is the HPS plus the memory it reads from.
interface prg_uploader_if;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        mem_rd;
    logic [24:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [15:0] upload_size;
    logic        size_valid;
    logic        uploading;

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_dout,
        output ioctl_din, ioctl_wait, mem_rd, mem_addr, upload_size, size_valid, uploading
    );

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_dout,
        input  ioctl_din, ioctl_wait, mem_rd, mem_addr, upload_size, size_valid, uploading
    );
endinterface

// File: rtl/prg_uploader.sv
// Streams the resident BASIC program from shared RAM to the HPS ioctl upload channel.
// Length comes from the END pointer; each byte request is paced with ioctl_wait.
module prg_uploader #(
    parameter logic [7:0]  PRG_INDEX      = 8'h01,
    parameter logic [24:0] PRG_START_ADDR = 25'h10995,
    parameter logic [24:0] PTR_PROGND     = 25'h103E9,
    parameter logic [15:0] PTR_END_BASE   = 16'h8995,
    parameter logic [15:0] MAX_LEN        = 16'h7000,
    parameter int          RD_LAT         = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    prg_uploader_if.slave  up_if
);

    typedef enum logic [2:0] {
        S_IDLE, S_PTR_LO, S_PTR_HI, S_CALC, S_READY, S_FETCH, S_DONE
    } state_t;

    localparam logic [1:0] LAT = 2'(RD_LAT);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  din_q, din_d;
    logic        wait_q, wait_d;
    logic        mem_rd_q, mem_rd_d;
    logic [24:0] mem_addr_q, mem_addr_d;
    logic [15:0] size_q, size_d;
    logic        valid_q, valid_d;
    logic        uploading_q, uploading_d;

    logic        start_hit;
    logic        rd_hit;
    logic        lat_hit;
    logic        abort;
    logic [15:0] ptr_w;
    logic [15:0] diff_w;
    logic [15:0] len_w;

    assign start_hit = up_if.ioctl_upload && (up_if.ioctl_index == PRG_INDEX);
    assign rd_hit    = (up_if.ioctl_addr[24:16] == 9'd0) && (up_if.ioctl_addr[15:0] < size_q);
    // cnt_q is cleared on the strobe edge, so it equals LAT on the edge the data is valid
    assign lat_hit   = (cnt_q == LAT);
    assign abort     = (state_q != S_IDLE) && (state_q != S_DONE) && !up_if.ioctl_upload;
    assign ptr_w     = {hi_q, lo_q};
    assign diff_w    = ptr_w - PTR_END_BASE;

    always_comb begin
        len_w = diff_w;
        if (ptr_w < PTR_END_BASE) begin
            len_w = 16'd0;
        end else if (diff_w > MAX_LEN) begin
            len_w = MAX_LEN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            lo_q        <= 8'd0;
            hi_q        <= 8'd0;
            din_q       <= 8'd0;
            wait_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= 25'd0;
            size_q      <= 16'd0;
            valid_q     <= 1'b0;
            uploading_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            din_q       <= din_d;
            wait_q      <= wait_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            size_q      <= size_d;
            valid_q     <= valid_d;
            uploading_q <= uploading_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end else if (abort) begin
            state_d = S_DONE;
        end else begin
            case (state_q)
                S_IDLE:   if (start_hit) state_d = S_PTR_LO;
                S_PTR_LO: if (lat_hit) state_d = S_PTR_HI;
                S_PTR_HI: if (lat_hit) state_d = S_CALC;
                S_CALC:   state_d = S_READY;
                S_READY:  if (up_if.ioctl_rd && rd_hit) state_d = S_FETCH;
                S_FETCH:  if (lat_hit) state_d = S_READY;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        din_d       = din_q;
        wait_d      = wait_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        size_d      = size_q;
        valid_d     = valid_q;
        uploading_d = uploading_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        cnt_d       = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
        if (abort) begin
            wait_d      = 1'b0;
            uploading_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_hit) begin
                        uploading_d = 1'b1;
                        wait_d      = 1'b1;
                        valid_d     = 1'b0;
                        mem_rd_d    = 1'b1;
                        mem_addr_d  = PTR_PROGND;
                        cnt_d       = 2'd0;
                    end
                end
                S_PTR_LO: begin
                    if (lat_hit) begin
                        lo_d       = up_if.mem_dout;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = PTR_PROGND + 25'd1;
                        cnt_d      = 2'd0;
                    end
                end
                S_PTR_HI: begin
                    if (lat_hit) hi_d = up_if.mem_dout;
                end
                S_CALC: begin
                    size_d  = len_w;
                    valid_d = 1'b1;
                    wait_d  = 1'b0;
                end
                S_READY: begin
                    if (up_if.ioctl_rd) begin
                        if (rd_hit) begin
                            mem_rd_d   = 1'b1;
                            mem_addr_d = PRG_START_ADDR + {9'd0, up_if.ioctl_addr[15:0]};
                            wait_d     = 1'b1;
                            cnt_d      = 2'd0;
                        end else begin
                            din_d = 8'h00;
                        end
                    end
                end
                S_FETCH: begin
                    if (lat_hit) begin
                        din_d  = up_if.mem_dout;
                        wait_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign up_if.ioctl_din   = din_q;
    assign up_if.ioctl_wait  = wait_q;
    assign up_if.mem_rd      = mem_rd_q;
    assign up_if.mem_addr    = mem_addr_q;
    assign up_if.upload_size = size_q;
    assign up_if.size_valid  = valid_q;
    assign up_if.uploading   = uploading_q;

endmodule
